// File: rtl/clk_div_ctrl_if.sv
// Ratio-change handshake bundle between requesters and the clock divider controller.
interface clk_div_ctrl_if #(
    parameter int DIV_RATIO_WIDTH = 8
);
    logic                       i_req0;
    logic                       i_req1;
    logic [DIV_RATIO_WIDTH-1:0] i_ratio0;
    logic [DIV_RATIO_WIDTH-1:0] i_ratio1;
    logic                       o_ack0;
    logic                       o_ack1;
    logic [DIV_RATIO_WIDTH-1:0] o_div_ratio;
    logic                       o_clk_en;
    logic                       o_busy;
    logic                       o_bypass;

    modport master (
        output i_req0, i_req1, i_ratio0, i_ratio1,
        input  o_ack0, o_ack1, o_div_ratio, o_clk_en, o_busy, o_bypass
    );

    modport slave (
        input  i_req0, i_req1, i_ratio0, i_ratio1,
        output o_ack0, o_ack1, o_div_ratio, o_clk_en, o_busy, o_bypass
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-safe divide-ratio controller: gates the divider, loads the new ratio, settles, then acks.
// Define CLK_DIV_CTRL_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module clk_div_ctrl #(
    parameter int DIV_RATIO_WIDTH = 8,
    parameter int DEFAULT_RATIO   = 8,
    parameter int SETTLE_CYCLES   = 4
) (
    input logic           i_ref_clk,
    input logic           i_rst_n,
    clk_div_ctrl_if.slave bus
);

    typedef enum logic [2:0] {START, IDLE, GATE, LOAD, SETTLE, ACK} state_t;

    localparam logic [DIV_RATIO_WIDTH-1:0] RESET_RATIO = DIV_RATIO_WIDTH'(DEFAULT_RATIO);
    localparam logic [3:0]                 SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t                     state_q, state_d;
    logic [DIV_RATIO_WIDTH-1:0] div_ratio_q, div_ratio_d;
    logic                       clk_en_q, clk_en_d;
    logic                       busy_q, busy_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       win_idx_q, win_idx_d;
    logic [DIV_RATIO_WIDTH-1:0] win_ratio_q, win_ratio_d;
    logic                       has_win_q, has_win_d;
    logic                       ack0, ack1;
    logic                       pick1;
    logic [DIV_RATIO_WIDTH-1:0] pick_ratio;

`ifdef CLK_DIV_CTRL_RR_EN
    // ptr_q holds the index served last, so the other requester wins a tie.
    logic ptr_q, ptr_d;
    assign pick1 = bus.i_req1 & (~bus.i_req0 | ~ptr_q);
`else
    assign pick1 = bus.i_req1 & ~bus.i_req0;
`endif
    assign pick_ratio = pick1 ? bus.i_ratio1 : bus.i_ratio0;

    always_comb begin
        state_d     = state_q;
        div_ratio_d = div_ratio_q;
        clk_en_d    = clk_en_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        win_idx_d   = win_idx_q;
        win_ratio_d = win_ratio_q;
        has_win_d   = has_win_q;
        ack0        = 1'b0;
        ack1        = 1'b0;
`ifdef CLK_DIV_CTRL_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            START: begin
                clk_en_d  = 1'b1;
                cnt_d     = 4'd0;
                has_win_d = 1'b0;
                state_d   = SETTLE;
            end
            IDLE: begin
                if (bus.i_req0 || bus.i_req1) begin
                    win_idx_d   = pick1;
                    win_ratio_d = pick_ratio;
                    has_win_d   = 1'b1;
                    busy_d      = 1'b1;
                    if (pick_ratio == div_ratio_q) begin
                        state_d = ACK;
                    end else begin
                        clk_en_d = 1'b0;
                        state_d  = GATE;
                    end
                end
            end
            GATE: begin
                div_ratio_d = win_ratio_q;
                state_d     = LOAD;
            end
            LOAD: begin
                clk_en_d = 1'b1;
                cnt_d    = 4'd0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    if (has_win_q) begin
                        state_d = ACK;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            ACK: begin
                ack0      = ~win_idx_q;
                ack1      = win_idx_q;
                busy_d    = 1'b0;
                has_win_d = 1'b0;
                state_d   = IDLE;
`ifdef CLK_DIV_CTRL_RR_EN
                ptr_d     = win_idx_q;
`endif
            end
            default: state_d = START;
        endcase
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= START;
            div_ratio_q <= RESET_RATIO;
            clk_en_q    <= 1'b0;
            busy_q      <= 1'b1;
            cnt_q       <= 4'd0;
            win_idx_q   <= 1'b0;
            win_ratio_q <= RESET_RATIO;
            has_win_q   <= 1'b0;
`ifdef CLK_DIV_CTRL_RR_EN
            ptr_q       <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            div_ratio_q <= div_ratio_d;
            clk_en_q    <= clk_en_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            win_idx_q   <= win_idx_d;
            win_ratio_q <= win_ratio_d;
            has_win_q   <= has_win_d;
`ifdef CLK_DIV_CTRL_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign bus.o_ack0      = ack0;
    assign bus.o_ack1      = ack1;
    assign bus.o_div_ratio = div_ratio_q;
    assign bus.o_clk_en    = clk_en_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_bypass    = (div_ratio_q < DIV_RATIO_WIDTH'(2));

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: vector table of single requests plus arbitration and reset sequences.
module tb_clk_div_ctrl;

    localparam int SC = 4;

    typedef struct {
        logic       sel;
        logic [7:0] ratio;
        int         exp_lat;
        int         exp_en_low;
        logic       exp_bypass;
    } vec_t;

    logic i_ref_clk = 1'b0;
    logic i_rst_n   = 1'b0;
    int   tests     = 0;
    int   failures  = 0;

    clk_div_ctrl_if #(.DIV_RATIO_WIDTH(8)) bus ();

    clk_div_ctrl #(
        .DIV_RATIO_WIDTH(8),
        .DEFAULT_RATIO  (8),
        .SETTLE_CYCLES  (SC)
    ) dut (
        .i_ref_clk(i_ref_clk),
        .i_rst_n  (i_rst_n),
        .bus      (bus)
    );

    always #5 i_ref_clk = ~i_ref_clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_ref_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sel, input logic [7:0] ratio, input logic level);
        if (sel) begin
            bus.i_ratio1 = ratio;
            bus.i_req1   = level;
        end else begin
            bus.i_ratio0 = ratio;
            bus.i_req0   = level;
        end
    endtask

    // One request from a single requester, tracked edge by edge from its sampling edge E0.
    task automatic runVector(input vec_t v);
        int         ack_at;
        int         en_low;
        int         other;
        logic [7:0] prev_ratio;
        logic       prev_en;
        ack_at = -1;
        en_low = 0;
        other  = 0;
        prev_ratio = bus.o_div_ratio;
        prev_en    = bus.o_clk_en;
        applyStimulus(v.sel, v.ratio, 1'b1);
        for (int n = 0; n < 40; n++) begin
            tick();
            if (!bus.o_clk_en) en_low++;
            checkOutput("ratio_en_same_cycle",
                        int'((bus.o_div_ratio != prev_ratio) && (bus.o_clk_en != prev_en)), 0);
            prev_ratio = bus.o_div_ratio;
            prev_en    = bus.o_clk_en;
            if (v.sel ? bus.o_ack0 : bus.o_ack1) other++;
            if (v.sel ? bus.o_ack1 : bus.o_ack0) begin
                ack_at = n;
                break;
            end
        end
        checkOutput("ack_latency", ack_at, v.exp_lat);
        applyStimulus(v.sel, v.ratio, 1'b0);
        checkOutput("clk_en_low_cycles", en_low, v.exp_en_low);
        checkOutput("other_ack", other, 0);
        checkOutput("div_ratio", int'(bus.o_div_ratio), int'(v.ratio));
        checkOutput("bypass", int'(bus.o_bypass), int'(v.exp_bypass));
        tick();
        checkOutput("ack_one_cycle", int'(bus.o_ack0 | bus.o_ack1), 0);
        checkOutput("busy_after_ack", int'(bus.o_busy), 0);
    endtask

    vec_t vecs[9];

    initial begin
        int first, second, got;
        int who[4];
        int when[4];
        int exp_who[4];
        int exp_gap;
        int exp_final;
        int acks;

        vecs[0] = '{sel: 1'b0, ratio: 8'd5,   exp_lat: 2+SC, exp_en_low: 2, exp_bypass: 1'b0};
        vecs[1] = '{sel: 1'b1, ratio: 8'd5,   exp_lat: 0,    exp_en_low: 0, exp_bypass: 1'b0};
        vecs[2] = '{sel: 1'b1, ratio: 8'd1,   exp_lat: 2+SC, exp_en_low: 2, exp_bypass: 1'b1};
        vecs[3] = '{sel: 1'b0, ratio: 8'd0,   exp_lat: 2+SC, exp_en_low: 2, exp_bypass: 1'b1};
        vecs[4] = '{sel: 1'b0, ratio: 8'd0,   exp_lat: 0,    exp_en_low: 0, exp_bypass: 1'b1};
        vecs[5] = '{sel: 1'b1, ratio: 8'd255, exp_lat: 2+SC, exp_en_low: 2, exp_bypass: 1'b0};
        vecs[6] = '{sel: 1'b0, ratio: 8'd2,   exp_lat: 2+SC, exp_en_low: 2, exp_bypass: 1'b0};
        vecs[7] = '{sel: 1'b1, ratio: 8'd8,   exp_lat: 2+SC, exp_en_low: 2, exp_bypass: 1'b0};
        vecs[8] = '{sel: 1'b1, ratio: 8'd8,   exp_lat: 0,    exp_en_low: 0, exp_bypass: 1'b0};

        bus.i_req0   = 1'b0;
        bus.i_req1   = 1'b0;
        bus.i_ratio0 = 8'd0;
        bus.i_ratio1 = 8'd0;

        #12;
        checkOutput("rst_div_ratio", int'(bus.o_div_ratio), 8);
        checkOutput("rst_clk_en", int'(bus.o_clk_en), 0);
        checkOutput("rst_busy", int'(bus.o_busy), 1);
        checkOutput("rst_acks", int'(bus.o_ack0 | bus.o_ack1), 0);
        checkOutput("rst_bypass", int'(bus.o_bypass), 0);

        // Start-up: clk_en rises on edge 1, busy falls on edge 1+SC, never an ack.
        @(negedge i_ref_clk);
        i_rst_n = 1'b1;
        for (int n = 1; n <= SC + 2; n++) begin
            tick();
            checkOutput("start_clk_en", int'(bus.o_clk_en), 1);
            checkOutput("start_busy", int'(bus.o_busy), (n < 1 + SC) ? 1 : 0);
            checkOutput("start_no_ack", int'(bus.o_ack0 | bus.o_ack1), 0);
        end
        checkOutput("start_ratio", int'(bus.o_div_ratio), 8);

        for (int i = 0; i < 9; i++) runVector(vecs[i]);

        // Simultaneous requests, each dropped on its own ack.
        first = -1; second = -1; got = 0;
        bus.i_ratio0 = 8'd4; bus.i_ratio1 = 8'd6;
        bus.i_req0 = 1'b1;   bus.i_req1 = 1'b1;
        for (int c = 0; c < 60 && got < 2; c++) begin
            tick();
            checkOutput("ack_exclusive", int'(bus.o_ack0 & bus.o_ack1), 0);
            if (bus.o_ack0) begin
                if (got == 0) first = 0; else second = 0;
                got++;
                bus.i_req0 = 1'b0;
            end
            if (bus.o_ack1) begin
                if (got == 0) first = 1; else second = 1;
                got++;
                bus.i_req1 = 1'b0;
            end
        end
        checkOutput("sim_first", first, 0);
        checkOutput("sim_second", second, 1);
        checkOutput("sim_final_ratio", int'(bus.o_div_ratio), 6);
        tick();
        checkOutput("sim_busy_done", int'(bus.o_busy), 0);

        // Both requests held continuously.
`ifdef CLK_DIV_CTRL_RR_EN
        exp_who   = '{0, 1, 0, 1};
        exp_gap   = 4 + SC;
        exp_final = 7;
`else
        exp_who   = '{0, 0, 0, 0};
        exp_gap   = 2;
        exp_final = 3;
`endif
        acks = 0;
        who  = '{-1, -1, -1, -1};
        when = '{0, 0, 0, 0};
        bus.i_ratio0 = 8'd3; bus.i_ratio1 = 8'd7;
        bus.i_req0 = 1'b1;   bus.i_req1 = 1'b1;
        for (int c = 0; c < 200 && acks < 4; c++) begin
            tick();
            checkOutput("hold_ack_exclusive", int'(bus.o_ack0 & bus.o_ack1), 0);
            if (bus.o_ack0 || bus.o_ack1) begin
                who[acks]  = bus.o_ack1 ? 1 : 0;
                when[acks] = c;
                acks++;
            end
        end
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b0;
        checkOutput("hold_ack_count", acks, 4);
        for (int k = 0; k < 4; k++) checkOutput("hold_winner", who[k], exp_who[k]);
        for (int k = 1; k < 4; k++) checkOutput("hold_ack_gap", when[k] - when[k-1], exp_gap);
        checkOutput("hold_final_ratio", int'(bus.o_div_ratio), exp_final);
        tick();
        checkOutput("hold_busy_done", int'(bus.o_busy), 0);

        // Reset asserted while a ratio-2 request is settling.
        applyStimulus(1'b0, 8'd2, 1'b1);
        for (int n = 0; n < 4; n++) tick();
        checkOutput("midrst_pre_ratio", int'(bus.o_div_ratio), 2);
        checkOutput("midrst_pre_clk_en", int'(bus.o_clk_en), 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("midrst_ratio", int'(bus.o_div_ratio), 8);
        checkOutput("midrst_clk_en", int'(bus.o_clk_en), 0);
        checkOutput("midrst_busy", int'(bus.o_busy), 1);
        checkOutput("midrst_acks", int'(bus.o_ack0 | bus.o_ack1), 0);
        checkOutput("midrst_bypass", int'(bus.o_bypass), 0);
        applyStimulus(1'b0, 8'd2, 1'b0);
        @(negedge i_ref_clk);
        i_rst_n = 1'b1;
        acks = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (bus.o_ack0 || bus.o_ack1) acks++;
        end
        checkOutput("midrst_no_ack", acks, 0);
        checkOutput("midrst_final_ratio", int'(bus.o_div_ratio), 8);
        checkOutput("midrst_final_busy", int'(bus.o_busy), 0);
        checkOutput("midrst_final_clk_en", int'(bus.o_clk_en), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
